if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch front end for the 5-stage pipeline; sole consumer of PCUnit's PC/PCplus4.
//  - Issues req/gnt reads to instruction memory.
//  - Loads the IF/ID pipeline register and holds it on a decode stall.
//  - Drives PCProtect back to PCUnit so PC advances only when its instruction is delivered.
//  - Flushes in-flight fetches on control-flow redirects; counts fetch-stall cycles.
// PARAMETERS
//  NOP_INSTR    32'h00000000  instruction word loaded into IF/ID on reset/flush
//  STALL_CNT_W  16            width of FetchStallCnt (saturating)
// PORTS
//  CLK            in   1   clock, rising edge
//  Reset_n        in   1   asynchronous, active-low reset
//  PC             in   32  current PC from PCUnit (bit31 = supervisor)
//  PCplus4        in   32  PCUnit's PC+4 (bit31 preserved)
//  Redirect       in   1   PCUnit loads a non-sequential PC at next edge (jump/JR/taken branch/exception)
//  ID_Stall       in   1   decode cannot accept a new instruction this cycle
//  IMemReq        out  1   instruction read request
//  IMemAddr       out  32  read address (= PC while IMemReq=1)
//  IMemGnt        in   1   request accepted this cycle
//  IMemRvalid     in   1   read data valid (>=1 cycle after the accepting gnt)
//  IMemRdata      in   32  read data
//  PCProtect      out  1   1 = PCUnit holds PC this cycle (combinational)
//  IF_ID_Instr    out  32  registered instruction to decode
//  IF_ID_PCplus4  out  32  registered PC+4 of that instruction
//  IF_ID_Valid    out  1   IF/ID holds a real instruction (0 = bubble)
//  FetchStallCnt  out  STALL_CNT_W  cycles with PCProtect=1 and Redirect=0
// BEHAVIOUR
//  Reset (async, any state):
//   - state=REQ; IF_ID_Instr=NOP_INSTR; IF_ID_PCplus4=0; IF_ID_Valid=0; FetchStallCnt=0; skid buffer empty.
//  States: REQ, WAIT, HOLD, DROP.
//   REQ:  IMemReq=1, IMemAddr=PC.
//         - gnt -> WAIT.
//         - no gnt -> stay.
//   WAIT: IMemReq=0.
//         - Rvalid & !ID_Stall -> deliver (IF_ID <= {Rdata, PCplus4}, Valid=1) -> REQ.
//         - Rvalid & ID_Stall  -> capture into skid buffer -> HOLD.
//   HOLD: IMemReq=0.
//         - !ID_Stall -> deliver from skid buffer -> REQ.
//   DROP: IMemReq=0; waits for the stale response.
//         - Rvalid -> discard data -> REQ.
//  PCProtect:
//   - 0 in a deliver cycle or whenever Redirect=1; 1 otherwise.
//   - PC therefore changes exactly once per delivered instruction.
//  Fetch latency: minimum 2 cycles per instruction (gnt cycle + rvalid cycle); no back-to-back issue.
//  IF/ID register:
//   - ID_Stall=1 and no Redirect: holds all fields.
//   - ID_Stall=0 and no deliver: Valid<=0 (bubble); Instr/PCplus4 hold.
//  Redirect (priority over ID_Stall and deliver):
//   - IF_ID_Valid<=0, IF_ID_Instr<=NOP_INSTR, PCProtect=0.
//   - REQ & gnt same cycle -> DROP (stale request issued).
//   - REQ & no gnt -> REQ.
//   - WAIT & no Rvalid -> DROP.
//   - WAIT & Rvalid -> REQ, data discarded.
//   - HOLD -> REQ, buffer cleared.
//   - DROP & Rvalid -> REQ; DROP & no Rvalid -> stays DROP.
//  FetchStallCnt:
//   - +1 each cycle with PCProtect=1 & Redirect=0.
//   - Saturates at all-ones; never wraps.
//  Protocol rules:
//   - IMemRvalid outside WAIT/DROP is ignored.
//   - At most one read outstanding.
// TESTING
//  1. Reset, PC=0x80000000, gnt same cycle, rvalid next cycle with 0x24080005:
//     -> IMemAddr=0x80000000; IF_ID_Instr=0x24080005, PCplus4=0x80000004, Valid=1; PCProtect=0 only in rvalid cycle.
//  2. Steady stream, gnt and rvalid always available:
//     -> one instruction every 2 cycles; FetchStallCnt +1 per instruction.
//  3. Rvalid while ID_Stall=1 for 3 cycles:
//     -> HOLD; PCProtect=1 throughout; delivery in first cycle ID_Stall=0; IF/ID unchanged during stall.
//  4. Redirect in WAIT, target 0x80000040:
//     -> IF_ID_Valid=0; stale rvalid discarded in DROP; next IMemAddr=0x80000040.
//  5. Redirect coincident with ID_Stall=1 and rvalid:
//     -> flush wins; PCProtect=0; buffer empty; state REQ.
//  6. Reset_n low while in HOLD:
//     -> all outputs at reset values immediately, without waiting for a clock edge.
//  7. Counter saturation with STALL_CNT_W=4:
//     -> FetchStallCnt reaches 4'hF and holds; never wraps.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: req/gnt reads from instruction memory, IF/ID register with
// a one-entry skid buffer for decode stalls, redirect flush and a saturating stall counter.
module if_fetch_unit #(
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   Reset_n,
  input  logic [31:0]            PC,
  input  logic [31:0]            PCplus4,
  input  logic                   Redirect,
  input  logic                   ID_Stall,
  output logic                   IMemReq,
  output logic [31:0]            IMemAddr,
  input  logic                   IMemGnt,
  input  logic                   IMemRvalid,
  input  logic [31:0]            IMemRdata,
  output logic                   PCProtect,
  output logic [31:0]            IF_ID_Instr,
  output logic [31:0]            IF_ID_PCplus4,
  output logic                   IF_ID_Valid,
  output logic [STALL_CNT_W-1:0] FetchStallCnt
);

  // state | meaning
  // REQ   | request outstanding on the bus, waiting for gnt
  // WAIT  | granted, waiting for rvalid
  // HOLD  | instruction parked in skid buffer while decode stalls
  // DROP  | stale request after a redirect, response will be discarded
  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;

  state_t      state;
  logic [31:0] skid_instr;
  logic        deliver;

  // PC is held while the instruction is in flight or parked, so PCplus4 still
  // belongs to the instruction being delivered from either WAIT or HOLD.
  assign deliver   = !Redirect && !ID_Stall &&
                     ((state == WAIT && IMemRvalid) || state == HOLD);
  assign PCProtect = !(deliver || Redirect);
  assign IMemReq   = (state == REQ);
  assign IMemAddr  = PC;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= REQ;
      skid_instr    <= NOP_INSTR;
      IF_ID_Instr   <= NOP_INSTR;
      IF_ID_PCplus4 <= 32'h0;
      IF_ID_Valid   <= 1'b0;
      FetchStallCnt <= '0;
    end else begin
      if (PCProtect && FetchStallCnt != '1)
        FetchStallCnt <= FetchStallCnt + STALL_CNT_W'(1);

      if (Redirect) begin
        IF_ID_Valid <= 1'b0;
        IF_ID_Instr <= NOP_INSTR;
      end else if (deliver) begin
        IF_ID_Instr   <= (state == HOLD) ? skid_instr : IMemRdata;
        IF_ID_PCplus4 <= PCplus4;
        IF_ID_Valid   <= 1'b1;
      end else if (!ID_Stall) begin
        IF_ID_Valid <= 1'b0;
      end

      case (state)
        REQ:
          if (IMemGnt) state <= Redirect ? DROP : WAIT;
        WAIT:
          if (Redirect) begin
            state <= IMemRvalid ? REQ : DROP;
          end else if (IMemRvalid) begin
            if (ID_Stall) begin
              skid_instr <= IMemRdata;
              state      <= HOLD;
            end else begin
              state <= REQ;
            end
          end
        HOLD:
          if (Redirect) begin
            skid_instr <= NOP_INSTR;
            state      <= REQ;
          end else if (!ID_Stall) begin
            state <= REQ;
          end
        DROP:
          if (IMemRvalid) state <= REQ;
        default:
          state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized memory/stall
// traffic against a transaction-level model of fetch order and stall counting.
module tb_if_fetch_unit;

  logic        CLK;
  logic        Reset_n;
  logic [31:0] PC, PCplus4;
  logic        Redirect, ID_Stall;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt, IMemRvalid;
  logic [31:0] IMemRdata;
  logic        PCProtect;
  logic [31:0] IF_ID_Instr, IF_ID_PCplus4;
  logic        IF_ID_Valid;
  logic [15:0] FetchStallCnt;

  logic        rst_sat_n;
  logic        s_req, s_prot, s_valid;
  logic [31:0] s_addr, s_instr, s_pc4;
  logic [3:0]  s_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_m;
  logic [31:0] rd_tgt;

  if_fetch_unit #(.NOP_INSTR(32'h0), .STALL_CNT_W(16)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .PC(PC), .PCplus4(PCplus4), .Redirect(Redirect),
    .ID_Stall(ID_Stall), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
    .IMemRvalid(IMemRvalid), .IMemRdata(IMemRdata), .PCProtect(PCProtect),
    .IF_ID_Instr(IF_ID_Instr), .IF_ID_PCplus4(IF_ID_PCplus4), .IF_ID_Valid(IF_ID_Valid),
    .FetchStallCnt(FetchStallCnt));

  if_fetch_unit #(.NOP_INSTR(32'h0), .STALL_CNT_W(4)) u_sat (
    .CLK(CLK), .Reset_n(rst_sat_n), .PC(32'h8000_0000), .PCplus4(32'h8000_0004),
    .Redirect(1'b0), .ID_Stall(1'b0), .IMemReq(s_req), .IMemAddr(s_addr), .IMemGnt(1'b0),
    .IMemRvalid(1'b0), .IMemRdata(32'h0), .PCProtect(s_prot), .IF_ID_Instr(s_instr),
    .IF_ID_PCplus4(s_pc4), .IF_ID_Valid(s_valid), .FetchStallCnt(s_cnt));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] pc_next(input logic [31:0] p);
    return {p[31], p[30:0] + 31'd4};
  endfunction

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
  endfunction

  // PCUnit model: PC moves only on an unprotected edge, to the target on a redirect.
  task automatic tick();
    logic pcp, rd;
    pcp = PCProtect;
    rd  = Redirect;
    @(posedge CLK);
    #1;
    if (!pcp) pc_m = rd ? rd_tgt : pc_next(pc_m);
    PC      = pc_m;
    PCplus4 = pc_next(pc_m);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    Reset_n    = 1'b0;
    Redirect   = 1'b0;
    ID_Stall   = 1'b0;
    IMemGnt    = 1'b0;
    IMemRvalid = 1'b0;
    IMemRdata  = 32'h0;
    rd_tgt     = 32'h0;
    pc_m       = 32'h8000_0000;
    PC         = pc_m;
    PCplus4    = pc_next(pc_m);
    #3;
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (IMemReq !== 1'b1) begin errors++; $display("FAIL reset_req: got %b expected 1", IMemReq); end
    checks++; if (PCProtect !== 1'b1) begin errors++; $display("FAIL reset_protect: got %b expected 1", PCProtect); end
    checks++; if (IMemAddr !== 32'h8000_0000) begin errors++; $display("FAIL reset_addr: got %h expected 80000000", IMemAddr); end
    checks++; if (IF_ID_Instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", IF_ID_Instr); end
    checks++; if (IF_ID_PCplus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h expected 00000000", IF_ID_PCplus4); end
    checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", IF_ID_Valid); end
    checks++; if (FetchStallCnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", FetchStallCnt); end
  endtask

  task automatic test_first_fetch();
    IMemGnt = 1'b1;
    #1;
    checks++; if (IMemAddr !== 32'h8000_0000) begin errors++; $display("FAIL ff_addr: got %h expected 80000000", IMemAddr); end
    checks++; if (PCProtect !== 1'b1) begin errors++; $display("FAIL ff_protect_gnt: got %b expected 1", PCProtect); end
    tick();
    IMemGnt = 1'b0; IMemRvalid = 1'b1; IMemRdata = 32'h2408_0005;
    #1;
    checks++; if (PCProtect !== 1'b0) begin errors++; $display("FAIL ff_protect_rvalid: got %b expected 0", PCProtect); end
    checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL ff_req_wait: got %b expected 0", IMemReq); end
    tick();
    IMemRvalid = 1'b0;
    #1;
    checks++; if (IF_ID_Instr !== 32'h2408_0005) begin errors++; $display("FAIL ff_instr: got %h expected 24080005", IF_ID_Instr); end
    checks++; if (IF_ID_PCplus4 !== 32'h8000_0004) begin errors++; $display("FAIL ff_pc4: got %h expected 80000004", IF_ID_PCplus4); end
    checks++; if (IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL ff_valid: got %b expected 1", IF_ID_Valid); end
    checks++; if (IMemAddr !== 32'h8000_0004) begin errors++; $display("FAIL ff_next_addr: got %h expected 80000004", IMemAddr); end
    checks++; if (FetchStallCnt !== 16'd1) begin errors++; $display("FAIL ff_cnt: got %0d expected 1", FetchStallCnt); end
  endtask

  task automatic test_stall_hold();
    IMemGnt = 1'b1;
    #1;
    tick();
    IMemGnt = 1'b0; IMemRvalid = 1'b1; IMemRdata = 32'h8C09_0010; ID_Stall = 1'b1;
    #1;
    checks++; if (PCProtect !== 1'b1) begin errors++; $display("FAIL hold_protect0: got %b expected 1", PCProtect); end
    tick();
    for (int i = 0; i < 2; i++) begin
      IMemRvalid = 1'b1; IMemRdata = 32'hFFFF_0000 + i;
      #1;
      checks++; if (PCProtect !== 1'b1) begin errors++; $display("FAIL hold_protect: got %b expected 1", PCProtect); end
      checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL hold_req: got %b expected 0", IMemReq); end
      tick();
      checks++; if (IF_ID_Instr !== 32'h2408_0005 || IF_ID_Valid !== 1'b0)
        begin errors++; $display("FAIL hold_ifid: got %h/%b expected 24080005/0", IF_ID_Instr, IF_ID_Valid); end
    end
    IMemRvalid = 1'b0; ID_Stall = 1'b0;
    #1;
    checks++; if (PCProtect !== 1'b0) begin errors++; $display("FAIL hold_release_protect: got %b expected 0", PCProtect); end
    tick();
    checks++; if (IF_ID_Instr !== 32'h8C09_0010) begin errors++; $display("FAIL hold_instr: got %h expected 8c090010", IF_ID_Instr); end
    checks++; if (IF_ID_PCplus4 !== 32'h8000_0008) begin errors++; $display("FAIL hold_pc4: got %h expected 80000008", IF_ID_PCplus4); end
    checks++; if (IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b expected 1", IF_ID_Valid); end
  endtask

  task automatic test_redirect_wait();
    IMemGnt = 1'b1;
    #1;
    tick();
    IMemGnt = 1'b0; Redirect = 1'b1; rd_tgt = 32'h8000_0040;
    #1;
    checks++; if (PCProtect !== 1'b0) begin errors++; $display("FAIL rw_protect: got %b expected 0", PCProtect); end
    tick();
    Redirect = 1'b0;
    checks++; if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 32'h0)
      begin errors++; $display("FAIL rw_flush: got %h/%b expected 00000000/0", IF_ID_Instr, IF_ID_Valid); end
    IMemRvalid = 1'b1; IMemRdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL rw_drop_req: got %b expected 0", IMemReq); end
    tick();
    IMemRvalid = 1'b0;
    #1;
    checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL rw_stale_valid: got %b expected 0", IF_ID_Valid); end
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h8000_0040)
      begin errors++; $display("FAIL rw_new_addr: got %b/%h expected 1/80000040", IMemReq, IMemAddr); end
    IMemGnt = 1'b1;
    tick();
    IMemGnt = 1'b0; IMemRvalid = 1'b1; IMemRdata = 32'h1111_1111;
    tick();
    IMemRvalid = 1'b0;
    checks++; if (IF_ID_Instr !== 32'h1111_1111 || IF_ID_PCplus4 !== 32'h8000_0044)
      begin errors++; $display("FAIL rw_refetch: got %h/%h expected 11111111/80000044", IF_ID_Instr, IF_ID_PCplus4); end
  endtask

  task automatic test_redirect_collide();
    IMemGnt = 1'b1;
    #1;
    tick();
    IMemGnt = 1'b0; Redirect = 1'b1; ID_Stall = 1'b1; IMemRvalid = 1'b1;
    IMemRdata = 32'hBAD0_BAD0; rd_tgt = 32'h8000_0100;
    #1;
    checks++; if (PCProtect !== 1'b0) begin errors++; $display("FAIL rc_protect: got %b expected 0", PCProtect); end
    tick();
    Redirect = 1'b0; ID_Stall = 1'b0; IMemRvalid = 1'b0;
    #1;
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h8000_0100)
      begin errors++; $display("FAIL rc_state: got %b/%h expected 1/80000100", IMemReq, IMemAddr); end
    checks++; if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 32'h0)
      begin errors++; $display("FAIL rc_flush: got %h/%b expected 00000000/0", IF_ID_Instr, IF_ID_Valid); end
    IMemGnt = 1'b1;
    tick();
    IMemGnt = 1'b0; IMemRvalid = 1'b1; IMemRdata = 32'h2222_2222;
    tick();
    IMemRvalid = 1'b0;
    checks++; if (IF_ID_Instr !== 32'h2222_2222 || IF_ID_PCplus4 !== 32'h8000_0104)
      begin errors++; $display("FAIL rc_refetch: got %h/%h expected 22222222/80000104", IF_ID_Instr, IF_ID_PCplus4); end
  endtask

  task automatic test_reset_in_hold();
    IMemGnt = 1'b1;
    tick();
    IMemGnt = 1'b0; IMemRvalid = 1'b1; IMemRdata = 32'h3333_3333;
    tick();
    IMemRvalid = 1'b0; ID_Stall = 1'b1; IMemGnt = 1'b1;
    tick();
    IMemGnt = 1'b0; IMemRvalid = 1'b1; IMemRdata = 32'h4444_4444;
    tick();
    IMemRvalid = 1'b0;
    #1;
    checks++; if (IF_ID_Valid !== 1'b1 || IF_ID_Instr !== 32'h3333_3333)
      begin errors++; $display("FAIL rh_pre: got %h/%b expected 33333333/1", IF_ID_Instr, IF_ID_Valid); end
    #1;
    Reset_n = 1'b0;
    #1;
    checks++; if (IMemReq !== 1'b1) begin errors++; $display("FAIL rh_req: got %b expected 1", IMemReq); end
    checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL rh_valid: got %b expected 0", IF_ID_Valid); end
    checks++; if (IF_ID_Instr !== 32'h0) begin errors++; $display("FAIL rh_instr: got %h expected 00000000", IF_ID_Instr); end
    checks++; if (IF_ID_PCplus4 !== 32'h0) begin errors++; $display("FAIL rh_pc4: got %h expected 00000000", IF_ID_PCplus4); end
    checks++; if (FetchStallCnt !== 16'd0) begin errors++; $display("FAIL rh_cnt: got %0d expected 0", FetchStallCnt); end
    ID_Stall = 1'b0;
    Reset_n  = 1'b1;
  endtask

  // Model: the k-th delivered instruction is memory at base+4k; every cycle that is not a
  // delivery is a stall cycle; IF/ID never changes across a stalled edge.
  task automatic test_random(input int n, input int gnt_pct, input int stall_pct,
                             input int maxdly, input bit exact_rate);
    logic        pending, stall_prev;
    int          dly, deliveries;
    logic [31:0] pend_addr, exp_addr, exp_del, s_i, s_p;
    logic        s_v;
    do_reset();
    pending = 1'b0; dly = 0; deliveries = 0;
    exp_addr = 32'h8000_0000; exp_del = 32'h8000_0000; pend_addr = 32'h0;
    for (int c = 0; c < n; c++) begin
      ID_Stall   = ($urandom_range(99) < stall_pct);
      IMemRvalid = 1'b0;
      IMemRdata  = $urandom;
      if (pending) begin
        if (dly == 0) begin
          IMemRvalid = 1'b1; IMemRdata = memf(pend_addr); pending = 1'b0;
        end else dly--;
      end
      IMemGnt = IMemReq && ($urandom_range(99) < gnt_pct);
      #1;
      if (IMemReq && IMemGnt) begin
        checks++; if (IMemAddr !== exp_addr) begin errors++; $display("FAIL rnd_addr: got %h expected %h", IMemAddr, exp_addr); end
        pend_addr = IMemAddr; exp_addr = pc_next(exp_addr);
        pending = 1'b1; dly = $urandom_range(maxdly);
      end
      stall_prev = ID_Stall; s_i = IF_ID_Instr; s_p = IF_ID_PCplus4; s_v = IF_ID_Valid;
      tick();
      if (stall_prev) begin
        checks++; if (IF_ID_Instr !== s_i || IF_ID_PCplus4 !== s_p || IF_ID_Valid !== s_v)
          begin errors++; $display("FAIL rnd_hold: got %h/%h/%b expected %h/%h/%b", IF_ID_Instr, IF_ID_PCplus4, IF_ID_Valid, s_i, s_p, s_v); end
      end else if (IF_ID_Valid) begin
        checks++; if (IF_ID_Instr !== memf(exp_del) || IF_ID_PCplus4 !== pc_next(exp_del))
          begin errors++; $display("FAIL rnd_deliver: got %h/%h expected %h/%h", IF_ID_Instr, IF_ID_PCplus4, memf(exp_del), pc_next(exp_del)); end
        exp_del = pc_next(exp_del);
        deliveries++;
      end
    end
    IMemGnt = 1'b0; IMemRvalid = 1'b0; ID_Stall = 1'b0;
    checks++; if (int'(FetchStallCnt) !== n - deliveries)
      begin errors++; $display("FAIL rnd_stallcnt: got %0d expected %0d", FetchStallCnt, n - deliveries); end
    if (exact_rate) begin
      checks++; if (deliveries !== n / 2) begin errors++; $display("FAIL stream_rate: got %0d expected %0d", deliveries, n / 2); end
    end else begin
      checks++; if (deliveries < n / 10) begin errors++; $display("FAIL rnd_progress: got %0d expected at least %0d", deliveries, n / 10); end
    end
  endtask

  task automatic test_saturation();
    @(posedge CLK);
    #1;
    rst_sat_n = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(posedge CLK);
      #1;
      checks++; if (s_cnt !== ((i > 15) ? 4'hF : 4'(i)))
        begin errors++; $display("FAIL sat_cnt: got %h expected %h at cycle %0d", s_cnt, (i > 15) ? 4'hF : 4'(i), i); end
    end
  endtask

  initial begin
    rst_sat_n = 1'b0;
    Reset_n   = 1'b0;
    test_reset();
    test_first_fetch();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_collide();
    test_reset_in_hold();
    test_random(200, 100, 0, 0, 1'b1);
    test_random(800, 60, 30, 2, 1'b0);
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
